// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues one imem request per cycle at the current PC, buffers
// returned instructions for decode, and drops stale responses after a redirect via an epoch bit.
`timescale 1ns/100ps
module fetch_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_pc_current,
    input  logic [1:0]  E_pc_src_sel,
    output logic        F_stall_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        D_stall,
    output logic        F_instr_valid,
    output logic [31:0] F_instr,
    output logic [31:0] F_instr_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic                         epoch;

    logic [DEPTH-1:0][31:0]       fl_addr;
    logic [DEPTH-1:0]             fl_ep;
    logic [PW-1:0]                fl_wr, fl_rd;
    logic [CW-1:0]                inflight;

    logic [DEPTH-1:0][31:0]       buf_instr;
    logic [DEPTH-1:0][31:0]       buf_pc;
    logic [PW-1:0]                buf_wr, buf_rd;
    logic [CW-1:0]                buf_cnt;

    logic                         redirect, fire, pop, rsp_keep;
    logic [CW:0]                  credit_use;

    assign redirect      = |E_pc_src_sel;
    assign F_instr_valid = (buf_cnt != '0);
    assign pop           = F_instr_valid & ~D_stall & ~redirect;

    // Credits cover both in-flight and buffered slots, so a response can never
    // find the buffer full; a slot freed by this cycle's pop is reusable at once.
    assign credit_use     = {1'b0, inflight} + {1'b0, buf_cnt} - {{CW{1'b0}}, pop};
    assign imem_req_valid = ~redirect & (credit_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = F_pc_current;
    assign fire           = imem_req_valid & imem_req_ready;
    assign F_stall_pc     = ~(fire | redirect);

    assign rsp_keep   = imem_rsp_valid & (fl_ep[fl_rd] == epoch) & ~redirect;
    assign F_instr    = buf_instr[buf_rd];
    assign F_instr_pc = buf_pc[buf_rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epoch    <= 1'b0;
            fl_addr  <= '0;
            fl_ep    <= '0;
            fl_wr    <= '0;
            fl_rd    <= '0;
            inflight <= '0;
        end else begin
            if (fire) begin
                fl_addr[fl_wr] <= F_pc_current;
                fl_ep[fl_wr]   <= epoch;
                fl_wr          <= fl_wr + 1'b1;
            end
            if (imem_rsp_valid)
                fl_rd <= fl_rd + 1'b1;
            inflight <= inflight + CW'(fire) - CW'(imem_rsp_valid);
            if (redirect)
                epoch <= ~epoch;
        end
    end

    // Redirect flushes the buffer outright; in-flight entries drain as discards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_instr <= '0;
            buf_pc    <= '0;
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_cnt   <= '0;
        end else if (redirect) begin
            buf_wr  <= '0;
            buf_rd  <= '0;
            buf_cnt <= '0;
        end else begin
            if (rsp_keep) begin
                buf_instr[buf_wr] <= imem_rsp_data;
                buf_pc[buf_wr]    <= fl_addr[fl_rd];
                buf_wr            <= buf_wr + 1'b1;
            end
            if (pop)
                buf_rd <= buf_rd + 1'b1;
            buf_cnt <= buf_cnt + CW'(rsp_keep) - CW'(pop);
        end
    end
endmodule
